// File: rtl/lsu_pricol_pkg.sv
// Shared load/store encodings and the LSU state type.
// The LDST_* values must match what the main decoder drives on mem_size.
package lsu_pricol_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } lsu_state_t;

  function automatic logic size_legal(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_H) || (size == LDST_W) ||
           (size == LDST_BU) || (size == LDST_HU);
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data lane select and sign/zero extension.
// Purely combinational: picks the byte/halfword lane out of the memory word.
module lsu_load_ext
  import lsu_pricol_pkg::*;
(
  input  logic [2:0]      size,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] rd
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = word[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? word[31:16] : word[15:0];
    case (size)
      LDST_B:  rd = {{24{byte_lane[7]}}, byte_lane};
      LDST_BU: rd = {24'b0, byte_lane};
      LDST_H:  rd = {{16{half_lane[15]}}, half_lane};
      LDST_HU: rd = {16'b0, half_lane};
      default: rd = word;
    endcase
  end

endmodule

// File: rtl/lsu_pricol.sv
// Load/store unit: turns a decoded core access into a byte-enabled memory
// transaction, stalls the core until memory is ready, and extends load data.
module lsu_pricol
  import lsu_pricol_pkg::*;
#(
  parameter int DATA_W = XLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [2:0]        core_size_i,
  input  logic [DATA_W-1:0] core_addr_i,
  input  logic [DATA_W-1:0] core_wd_i,
  output logic [DATA_W-1:0] core_rd_o,
  output logic              core_stall_o,
  output logic              core_misalign_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_be_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  input  logic              mem_ready_i,
  output lsu_state_t        dbg_state_o
);

  // Handshake: mem_req_o is a valid that stays high (with stable address,
  // data and enables) until the cycle mem_ready_i is seen in BUSY; that
  // cycle completes the transfer and releases core_stall_o.

  lsu_state_t  state_q, state_d;
  logic        bad_align;
  logic [3:0]  be;
  logic [31:0] wd_rep;
  logic [31:0] ext_rd;

  always_comb begin
    bad_align = 1'b0;
    if (!size_legal(core_size_i))
      bad_align = 1'b1;
    else if ((core_size_i == LDST_H || core_size_i == LDST_HU) && core_addr_i[0])
      bad_align = 1'b1;
    else if (core_size_i == LDST_W && core_addr_i[1:0] != 2'b00)
      bad_align = 1'b1;
  end

  assign core_misalign_o = core_req_i && bad_align;

  always_comb begin
    state_d      = state_q;
    mem_req_o    = 1'b0;
    core_stall_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (core_req_i && !bad_align) begin
          mem_req_o    = 1'b1;
          core_stall_o = 1'b1;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        // Ready completes the access; core inputs are assumed held until then.
        mem_req_o    = 1'b1;
        core_stall_o = !mem_ready_i;
        if (mem_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    case (core_size_i)
      LDST_B, LDST_BU: be = 4'b0001 << core_addr_i[1:0];
      LDST_H, LDST_HU: be = 4'b0011 << {core_addr_i[1], 1'b0};
      LDST_W:          be = 4'b1111;
      default:         be = 4'b0000;
    endcase
    case (core_size_i)
      LDST_B, LDST_BU: wd_rep = {4{core_wd_i[7:0]}};
      LDST_H, LDST_HU: wd_rep = {2{core_wd_i[15:0]}};
      default:         wd_rep = core_wd_i;
    endcase
  end

  // Memory-side fields are quiet whenever no request is on the bus.
  assign mem_we_o   = mem_req_o && core_we_i;
  assign mem_be_o   = mem_req_o ? be : 4'b0000;
  assign mem_addr_o = mem_req_o ? core_addr_i : '0;
  assign mem_wd_o   = mem_req_o ? wd_rep : '0;

  lsu_load_ext u_load_ext (
    .size    (core_size_i),
    .addr_lo (core_addr_i[1:0]),
    .word    (mem_rd_i),
    .rd      (ext_rd)
  );

  assign core_rd_o   = (state_q == BUSY && mem_ready_i && !core_we_i) ? ext_rd : '0;
  assign dbg_state_o = state_q;

endmodule

// File: doc/lsu_pricol.md
Name: lsu_pricol

Overview:
Load/store unit. It is the responder for the memory-control fields the main decoder produces (mem_req/mem_we/mem_size), and it sits between the core datapath and the data memory.
- Converts a core access into a byte-enabled memory transaction.
- Stalls the core until the memory signals ready.
- Sign- or zero-extends load data.
- Flags misaligned accesses without issuing them.

Parameters:
DATA_W, 32, data and address width (fixed 32; exposed for package consistency only)

Ports:
clk_i  in  1  system clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
core_req_i  in  1  core requests a memory access (decoder mem_req)
core_we_i  in  1  1 = store, 0 = load (decoder mem_we)
core_size_i  in  3  access size, LDST_* encoding (decoder mem_size)
core_addr_i  in  32  byte address from ALU
core_wd_i  in  32  store data (rs2)
core_rd_o  out  32  extended load data
core_stall_o  out  1  hold PC/pipeline while high
core_misalign_o  out  1  access is misaligned; no transaction issued
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  byte enables
mem_addr_o  out  32  memory byte address
mem_wd_o  out  32  replicated store data
mem_rd_i  in  32  memory read word
mem_ready_i  in  1  memory completes current request

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset state and outputs:
  - During rst_i and after reset: state=IDLE.
  - core_stall_o=0, mem_req_o=0, mem_we_o=0, mem_be_o=0, core_misalign_o=0, core_rd_o=0.
- Size encoding (LDST_*): B=0, H=1, W=2, BU=4, HU=5. Any other value is treated as illegal: no request, no stall, misalign_o=1.
- Misalignment:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - When misaligned: misalign_o=1 combinationally while core_req_i=1, mem_req_o=0, stall_o=0, state unchanged.
- FSM states: IDLE, BUSY.
  - IDLE, valid aligned core_req_i: mem_req_o=1 and stall_o=1 combinationally in the same cycle; next state BUSY.
  - IDLE, no request: all mem outputs 0, stall_o=0.
  - BUSY: mem_req_o=1 and mem_we_o held.
    - mem_ready_i=0: stall_o=1, remain in BUSY.
    - mem_ready_i=1: stall_o=0 and core_rd_o is valid this cycle; next state IDLE.
  - mem_ready_i is ignored in IDLE.
  - Minimum access latency is 2 cycles. Back-to-back accesses each take ≥2 cycles, since the new request is seen in IDLE.
- Stability: core inputs are stable while stalled, so mem_addr_o, mem_we_o, mem_be_o and mem_wd_o are combinational from the core inputs.
  - mem_addr_o = core_addr_i, passed through unmodified.
- Byte enables:
  - B/BU: 4'b0001 << addr[1:0].
  - H/HU: 4'b0011 << addr[1:0], with addr[1] in {0,1} only.
  - W: 4'b1111.
  - Loads drive the same be.
- Store data:
  - B: {4{wd[7:0]}}.
  - H: {2{wd[15:0]}}.
  - W: wd.
- Load extraction (from mem_rd_i):
  - Byte lane is selected by addr[1:0]; halfword lane by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - core_rd_o is combinational and is 0 when not (BUSY & mem_ready_i & ~we).
- Reset mid-access (rst_i in BUSY): return to IDLE, drop mem_req_o and stall_o the next cycle. The in-flight memory response is discarded.
- core_req_i dropping in BUSY is a protocol violation; the FSM still waits for ready.

Decomposition:
- riscv_pkg gains the LDST_B/H/W/BU/HU localparams and an lsu_state_t enum {IDLE, BUSY}.
- One natural sub-module: lsu_load_ext, a combinational lane select plus extension taking size, addr[1:0] and the word.

Test Plan:
- Reset: hold rst_i 2 cycles during a BUSY access -> next cycle stall_o=0, mem_req_o=0, state IDLE.
- SB: addr=0x103, wd=0xA5, ready after 3 cycles:
  - be=1000, mem_wd_o=0xA5A5A5A5, we=1.
  - stall_o high for 3 cycles, low in the ready cycle.
- LB/LBU: addr=0x202, mem_rd_i=0x0080FF00, ready next cycle:
  - LB -> core_rd_o=0xFFFFFF80.
  - LBU -> core_rd_o=0x00000080.
- LH/LHU: addr=0x06, mem_rd_i=0x8001_1234:
  - LH -> 0xFFFF8001, be=1100.
  - LHU -> 0x00008001.
- LW: addr=0x8 with ready immediate -> latency exactly 2 cycles. Two back-to-back LWs -> stall pattern 1,0,1,0.
- Misaligned: SW addr=0x2 or LH addr=0x1 -> misalign_o=1, mem_req_o=0, stall_o=0. size=3 -> same response.
